// File: rtl/vga_frame_reader.sv
// Streams a block of memory words out of an Avalon-MM slave into an Avalon-ST source.
// Reads are credit-limited so the output FIFO can never overflow.
module vga_frame_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_startofpacket,
  output logic                st_endofpacket,
  output logic [1:0]          dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W + 1;

  // Handshakes: an MM read is issued on a cycle with avm_read=1 and
  // avm_waitrequest=0; an ST word moves on a cycle with st_valid=1 and st_ready=1.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
  logic [IDX_W-1:0]   len_q, len_d, issue_idx_q, issue_idx_d, out_idx_q, out_idx_d;
  logic [CNT_W-1:0]   outst_q, outst_d, count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               read_q, read_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic               issued, fifo_wr, fifo_rd, last_out;
  logic [CNT_W:0]     credit;

  always_comb begin
    issued      = read_q & ~avm_waitrequest;
    // Responses arriving while idle belong to an aborted transfer and are dropped.
    fifo_wr     = avm_readdatavalid & (state_q != S_IDLE);
    fifo_rd     = (count_q != '0) & st_ready;
    last_out    = fifo_rd & (out_idx_q == len_q - IDX_W'(1));

    outst_d     = outst_q + CNT_W'(issued) - CNT_W'(fifo_wr);
    count_d     = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    wr_ptr_d    = wr_ptr_q + PTR_W'(fifo_wr);
    rd_ptr_d    = rd_ptr_q + PTR_W'(fifo_rd);
    issue_idx_d = issue_idx_q + IDX_W'(issued);
    out_idx_d   = out_idx_q + IDX_W'(fifo_rd);
    credit      = {1'b0, outst_d} + {1'b0, count_d};

    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    read_d  = read_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = S_ISSUE;
            base_d      = base_addr;
            len_d       = {1'b0, length};
            read_d      = 1'b1;
            addr_d      = base_addr;
            busy_d      = 1'b1;
            issue_idx_d = '0;
            out_idx_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issued && (issue_idx_d == len_q)) begin
          state_d = S_DRAIN;
          read_d  = 1'b0;
        end else if (!(read_q && avm_waitrequest)) begin
          // Credit counts every word already requested or still buffered.
          read_d = (issue_idx_d < len_q) && (credit < (CNT_W + 1)'(FIFO_DEPTH));
          addr_d = base_q + issue_idx_d[ADDR_W-1:0];
        end
      end
      default: ;
    endcase

    if ((state_q != S_IDLE) && last_out) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      read_d      = 1'b0;
      issue_idx_d = '0;
      out_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_idx_q <= '0;
      out_idx_q   <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_idx_q <= issue_idx_d;
      out_idx_q   <= out_idx_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= avm_readdata;
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign avm_read         = read_q;
  assign avm_address      = addr_q;
  assign avm_byteenable   = '1;
  assign st_valid         = (count_q != '0);
  assign st_data          = fifo_mem_q[rd_ptr_q];
  assign st_startofpacket = st_valid & (out_idx_q == '0);
  assign st_endofpacket   = st_valid & (out_idx_q == len_q - IDX_W'(1));
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: randomized memory slave and ST sink, with a
// queue-based model of the expected address and word streams.
module tb_vga_frame_reader;
  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [DW/8-1:0] avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b0;
  logic          st_startofpacket, st_endofpacket;
  logic [1:0]    dbg_state;

  vga_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [DW+1:0] exp_q[$];       // {sop, eop, data}
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] stall_log[$];
  logic [DW-1:0] rsp_data_q[$];
  int            rsp_due_q[$];
  int            last_due = 0;
  logic          model_busy = 1'b0, exp_done = 1'b0;
  int            n_issued = 0, n_delivered = 0;
  int            wr_mode = 0, rdy_mode = 0, lat_mode = 0, stall_left = 0;
  logic          prev_read = 0, prev_wait = 0, prev_valid = 0, prev_ready = 0, prev_rdv = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW+1:0] prev_st = '0;
  logic [DW-1:0] first_word = '0;
  int            eop_cyc = -10, done_cyc = -20;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 2'b10, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: resolve what the coming rising edge does, then check after it.
  task automatic tick();
    logic          rd_acc, st_acc, was_busy;
    logic [DW+1:0] e;
    logic [AW-1:0] a;
    int            due, len_i;
    rd_acc   = avm_read && !avm_waitrequest;
    st_acc   = st_valid && st_ready;
    was_busy = model_busy;
    exp_done = 1'b0;
    if (rd_acc) begin
      if (addr_q.size() == 0) chk("spurious_read", 1, 0);
      else chk("read_addr", avm_address, addr_q.pop_front());
      addr_log.push_back(avm_address);
      n_issued++;
      chk("credit", (n_issued - n_delivered) <= DEPTH, 1);
      due = cyc + ((lat_mode == 0) ? 1 : $urandom_range(1, 4));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_due_q.push_back(due);
      rsp_data_q.push_back(mem_word(avm_address));
    end
    if (st_acc) begin
      if (exp_q.size() == 0) chk("spurious_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("st_word", {st_startofpacket, st_endofpacket, st_data}, e);
        if (e[DW+1]) first_word = st_data;
        n_delivered++;
        if (e[DW]) begin
          model_busy = 1'b0;
          exp_done   = 1'b1;
          eop_cyc    = cyc;
        end
      end
    end
    if (start && !was_busy) begin
      len_i = int'(length);
      if (len_i == 0) exp_done = 1'b1;
      else begin
        model_busy  = 1'b1;
        n_issued    = 0;
        n_delivered = 0;
        addr_log.delete();
        for (int i = 0; i < len_i; i++) begin
          a = base_addr + AW'(i);
          addr_q.push_back(a);
          exp_q.push_back({(i == 0), (i == len_i - 1), mem_word(a)});
        end
      end
    end
    prev_read  = avm_read;
    prev_wait  = avm_waitrequest;
    prev_addr  = avm_address;
    prev_valid = st_valid;
    prev_ready = st_ready;
    prev_st    = {st_startofpacket, st_endofpacket, st_data};
    prev_rdv   = avm_readdatavalid && was_busy;

    @(posedge clk);
    @(negedge clk);
    cyc++;

    chk("busy", busy, model_busy);
    chk("done", done, exp_done);
    if (done) done_cyc = cyc;
    if (prev_read && prev_wait) begin
      chk("wait_hold_read", avm_read, 1);
      chk("wait_hold_addr", avm_address, prev_addr);
    end
    if (prev_valid && !prev_ready) begin
      chk("st_hold_valid", st_valid, 1);
      chk("st_hold_word", {st_startofpacket, st_endofpacket, st_data}, prev_st);
    end
    if (prev_rdv) chk("rdv_to_valid_latency", st_valid, 1);
    if (addr_q.size() == 0) chk("no_extra_read", avm_read, 0);
    if (!model_busy) chk("idle_valid", st_valid, 0);

    case (wr_mode)
      0: avm_waitrequest = 1'b0;
      1: avm_waitrequest = ($urandom_range(0, 2) == 0);
      default: begin
        if (avm_read && n_issued == 1 && stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          stall_log.push_back(avm_address);
        end else avm_waitrequest = 1'b0;
      end
    endcase
    case (rdy_mode)
      0: st_ready = 1'b1;
      1: st_ready = ($urandom_range(0, 1) == 1);
      default: st_ready = 1'b0;
    endcase
    if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
      void'(rsp_due_q.pop_front());
      avm_readdatavalid = 1'b1;
      avm_readdata      = rsp_data_q.pop_front();
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
    end
  endtask

  task automatic begin_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0; base_addr = AW'($urandom); length = AW'($urandom);
  endtask

  task automatic finish_xfer();
    int guard = 0;
    while (model_busy && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) begin
      chk("xfer_timeout", 1, 0);
      model_busy = 1'b0;
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l);
    begin_xfer(b, l);
    finish_xfer();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_valid", st_valid, 0);
    chk("rst_sop", st_startofpacket, 0);
    chk("rst_eop", st_endofpacket, 0);
    chk("byteenable", avm_byteenable, 4'hF);
    reset_n  = 1'b1;
    st_ready = 1'b1;
    tick();

    // Basic: latency-1 slave, always-ready sink
    run_xfer(15'h0100, 15'd4);
    chk("basic_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("basic_addr", addr_log[i], 15'h0100 + 15'(i));
    chk("basic_first_word", first_word, 32'h0201_7EFF);
    chk("basic_done_after_eop", done_cyc, eop_cyc + 1);

    // Back-to-back: start on the done cycle; second read stalled 3 cycles
    wr_mode = 2; stall_left = 3;
    run_xfer(15'h0200, 15'd3);
    chk("stall_cycles", stall_log.size(), 3);
    for (int i = 0; i < stall_log.size(); i++) chk("stall_addr", stall_log[i], 15'h0201);
    chk("stall_nreads", n_issued, 3);
    wr_mode = 0;

    // Sink stalled 20 cycles: reads stop at the FIFO depth
    rdy_mode = 2;
    begin_xfer(15'h0300, 15'd16);
    repeat (20) tick();
    chk("blocked_nreads", n_issued, DEPTH);
    chk("blocked_ndelivered", n_delivered, 0);
    rdy_mode = 1;
    finish_xfer();
    chk("blocked_total", n_delivered, 16);

    // Address wrap
    rdy_mode = 0;
    run_xfer(15'h7FFE, 15'd4);
    chk("wrap_a0", addr_log[0], 15'h7FFE);
    chk("wrap_a1", addr_log[1], 15'h7FFF);
    chk("wrap_a2", addr_log[2], 15'h0000);
    chk("wrap_a3", addr_log[3], 15'h0001);

    // Zero and single-word lengths
    repeat (2) tick();
    run_xfer(15'h0050, 15'd0);
    repeat (3) tick();
    run_xfer(15'h1234, 15'd1);
    chk("single_nreads", n_issued, 1);

    // Start while busy is ignored
    wr_mode = 1; lat_mode = 1; rdy_mode = 1;
    begin_xfer(15'h0600, 15'd6);
    repeat (2) tick();
    begin_xfer(15'h0999, 15'd3);
    finish_xfer();
    chk("busy_start_nreads", n_issued, 6);

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      wr_mode  = $urandom_range(0, 1);
      lat_mode = $urandom_range(0, 1);
      rdy_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) tick();
      run_xfer(AW'($urandom), AW'($urandom_range(1, 40)));
    end

    // Reset in the middle of a transfer
    wr_mode = 0; lat_mode = 1; rdy_mode = 1;
    begin
      int guard = 0;
      begin_xfer(15'h0400, 15'd10);
      while (n_delivered < 5 && guard < 500) begin
        tick();
        guard++;
      end
      chk("abort_reached_word5", n_delivered, 5);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_read", avm_read, 0);
    chk("abort_addr", avm_address, 0);
    chk("abort_valid", st_valid, 0);
    chk("abort_sop", st_startofpacket, 0);
    chk("abort_eop", st_endofpacket, 0);
    exp_q.delete(); addr_q.delete();
    model_busy = 1'b0; exp_done = 1'b0;
    avm_readdatavalid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    prev_read = 0; prev_valid = 0; prev_rdv = 0;
    repeat (10) tick();
    run_xfer(15'h0410, 15'd7);
    chk("post_abort_nreads", n_issued, 7);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two; output FIFO entries and maximum outstanding reads.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address; sampled on accepted start.
REQ-008 SHALL have port length  in  ADDR_W  word count; sampled on accepted start.
REQ-009 SHALL have port busy  out  1  high from accepted start until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have port avm_address  out  ADDR_W  Avalon-MM master word address.
REQ-012 SHALL have port avm_read  out  1  read request.
REQ-013 SHALL have port avm_byteenable  out  DATA_W/8  tied all-ones.
REQ-014 SHALL have port avm_waitrequest  in  1  slave stall.
REQ-015 SHALL have port avm_readdata  in  DATA_W  read data.
REQ-016 SHALL have port avm_readdatavalid  in  1  read data qualifier; responses return in issue order.
REQ-017 SHALL have port st_data  out  DATA_W  Avalon-ST source data.
REQ-018 SHALL have port st_valid / st_ready  out / in  1  ST handshake.
REQ-019 SHALL have port st_startofpacket / st_endofpacket  out  1  first / last word markers.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: start=1 with length>0 latches base_addr/length and goes to ISSUE.
- Same with length=0: done=1 next cycle, no reads, stays IDLE.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL assert a read in ISSUE when words_left>0 and credit = issued_not_returned + fifo_count < FIFO_DEPTH.
REQ-023 SHALL hold avm_read, avm_address stable while avm_waitrequest=1; a read is issued on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-024 SHALL form avm_address = base + issue_index, truncated to ADDR_W (wrap 2^ADDR_W-1 -> 0).
REQ-025 SHALL go ISSUE -> DRAIN on the cycle the last read issues; avm_read=0 in DRAIN and IDLE.
REQ-026 SHALL write each avm_readdatavalid word into the FIFO the same cycle; credit guarantees no overflow.
REQ-027 SHALL allow simultaneous FIFO write and read; a count-neutral event.
REQ-028 SHALL present the FIFO head on st_data with st_valid=1 whenever FIFO is non-empty; word transfers when st_valid & st_ready.
REQ-029 SHALL hold st_data and the markers stable while st_valid=1 and st_ready=0.
REQ-030 SHALL drive st_startofpacket=1 on output word 0 and st_endofpacket=1 on word length-1; both on a single-word transfer.
REQ-031 SHALL complete when the endofpacket word transfers: done=1 for the next cycle, busy=0 the same cycle, FSM IDLE.
REQ-032 SHALL accept a new start on the cycle done is high.
REQ-033 SHALL keep output latency no worse than first st_valid two cycles after the first readdatavalid.
REQ-034 SHALL use ADDR_W+1-bit counters for issue and output indices so length up to 2^ADDR_W-1 counts without overflow.

Reset
REQ-035 SHALL on reset_n=0 asynchronously force FSM IDLE, busy=0, done=0, avm_read=0, avm_address=0, st_valid=0, st_startofpacket=0, st_endofpacket=0, FIFO empty, all counters 0.
REQ-036 SHALL treat reset mid-transfer as an abort: in-flight readdatavalid after reset release is discarded while IDLE.

Verification
REQ-037 Fixed-latency-1 slave, st_ready=1, base=0x0100, length=4 -> reads 0x0100..0x0103, 4 ST words, sop on word 0, eop on word 3, done one cycle after word 3.
REQ-038 waitrequest high 3 cycles on 2nd read, length=3 -> avm_address held at base+1 for those cycles; data order preserved; exactly 3 reads issued.
REQ-039 st_ready=0 for 20 cycles, length=16, FIFO_DEPTH=8 -> at most 8 reads issued before stall; no FIFO overflow; all 16 words delivered in order after st_ready=1.
REQ-040 base=0x7FFE, length=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-041 length=0 -> no avm_read, done pulse next cycle; length=1 -> single word with sop=eop=1.
REQ-042 reset_n low mid-transfer (word 5 of 10) -> all outputs at reset values immediately; a new start after release runs cleanly.
